// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display path.
// Segment vectors use bit order {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned PTR_W      = $clog2(NUM_DIGITS);
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b000_0000;
    localparam logic [SEG_W-1:0] SEG_0   = 7'b111_1110;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b011_0000;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b110_1101;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b111_1001;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b011_0011;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b101_1011;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b101_1111;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b111_0000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b111_1111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b111_1011;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b111_0111;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b001_1111;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b100_1110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b011_1101;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b100_1111;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b100_0111;

    // Registered display drive: digit enables, segments, decimal point.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] pos;
        logic [SEG_W-1:0]      seg;
        logic                  dp;
    } disp_t;

    localparam disp_t DISP_OFF = '0;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to 7-segment pattern lookup.
// Ports:
//   digit  in  4  hex value 0-F
//   seg_c  out 7  segment pattern {a,b,c,d,e,f,g}, active-high (combinational)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (digit)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-cathode 7-segment scan driver with anti-ghosting
// blank gap and fixed decimal-point pattern.
// Optional feature: define SEG_LZB_EN for leading-zero blanking of digits 3/2.
// Ports:
//   clk         in  1  system clock, rising edge
//   reset       in  1  synchronous, active-high
//   scan        in  1  single-cycle scan-step strobe
//   d0..d3      in  4  digit values, d0 rightmost
//   pos         out 4  one-hot digit enable, active-high (registered)
//   a..g        out 1  segment drives, active-high (registered)
//   dp          out 1  decimal point, active-high (registered)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned           BLANK_CYCLES = 4,
    parameter logic [NUM_DIGITS-1:0] DP_MASK      = 4'b1010
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan,
    input  logic [DIGIT_W-1:0]    d0,
    input  logic [DIGIT_W-1:0]    d1,
    input  logic [DIGIT_W-1:0]    d2,
    input  logic [DIGIT_W-1:0]    d3,
    output logic [NUM_DIGITS-1:0] pos,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  e,
    output logic                  f,
    output logic                  g,
    output logic                  dp
);

    localparam int unsigned     CNT_W    = (BLANK_CYCLES == 0) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;
    disp_t              disp_q, disp_d;
    logic [DIGIT_W-1:0] digit_sel_c;
    logic [SEG_W-1:0]   seg_c;

    // Select the digit addressed by the scan pointer; inputs are tracked live.
    always_comb begin
        digit_sel_c = d0;
        case (ptr_q)
            2'd0: digit_sel_c = d0;
            2'd1: digit_sel_c = d1;
            2'd2: digit_sel_c = d2;
            2'd3: digit_sel_c = d3;
            default: digit_sel_c = d0;
        endcase
    end

    seg7_decode u_decode (
        .digit (digit_sel_c),
        .seg_c (seg_c)
    );

`ifdef SEG_LZB_EN
    logic lead_zero_c;

    // Digit 3 blanks on a zero; digit 2 blanks only when digit 3 is also zero.
    always_comb begin
        lead_zero_c = (d3 == '0) &&
                      ((ptr_q == PTR_W'(3)) || ((ptr_q == PTR_W'(2)) && (d2 == '0)));
    end
`endif

    // Next-state: scan restarts the gap, gap counts down, then the selected digit is driven.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        seen_d = seen_q;
        disp_d = DISP_OFF;
        if (scan) begin
            ptr_d  = ptr_q + PTR_W'(1);
            cnt_d  = CNT_LOAD;
            seen_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (seen_q) begin
            disp_d.pos = NUM_DIGITS'(1) << ptr_q;
            disp_d.seg = seg_c;
            disp_d.dp  = DP_MASK[ptr_q];
`ifdef SEG_LZB_EN
            if (lead_zero_c) begin
                disp_d.seg = SEG_OFF;
                disp_d.dp  = 1'b0;
            end
`endif
        end
    end

    // State and output registers; reset parks the pointer with the display dark.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
            disp_q <= DISP_OFF;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
            disp_q <= disp_d;
        end
    end

    assign pos = disp_q.pos;
    assign a   = disp_q.seg[6];
    assign b   = disp_q.seg[5];
    assign c   = disp_q.seg[4];
    assign d   = disp_q.seg[3];
    assign e   = disp_q.seg[2];
    assign f   = disp_q.seg[1];
    assign g   = disp_q.seg[0];
    assign dp  = disp_q.dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (BLANK_CYCLES=4, DP_MASK=1010).
// Expected display states are queued with a due cycle and compared at negedge.
module tb_seg7_scan_driver;

    localparam int unsigned N   = 4;
    localparam logic [3:0]  DPM = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] pos;
    logic       sa, sb_, sc, sd, se, sf, sg;
    logic       dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.BLANK_CYCLES(N), .DP_MASK(DPM)) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (scan),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .pos   (pos),
        .a     (sa),
        .b     (sb_),
        .c     (sc),
        .d     (sd),
        .e     (se),
        .f     (sf),
        .g     (sg),
        .dp    (dp)
    );

    typedef struct {
        int         due;
        int         tag;
        logic [3:0] pos;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic [3:0] pos;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Segment pattern from a list of lit segment letters, e.g. "abcdg".
    function automatic logic [6:0] segs(input string s);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[3'(6 - (int'(s[i]) - 97))] = 1'b1;
        return r;
    endfunction

    task automatic push(input int due, input logic [3:0] p, input logic [6:0] s, input logic dpv);
        exp_t ex;
        ex.due = due; ex.tag = tag; ex.pos = p; ex.seg = s; ex.dp = dpv;
        sbq.push_back(ex);
    endtask

    // Pulse scan for one cycle; queue the N+1 dark cycles and optionally the lit digit.
    task automatic do_scan(input logic [3:0] p, input logic [6:0] s, input logic dpv, input bit show);
        int         base;
        logic [6:0] es;
        logic       edp;
        base = cyc;
        es   = s;
        edp  = dpv;
`ifdef SEG_LZB_EN
        if ((p[3] && d3 == 4'd0) || (p[2] && d3 == 4'd0 && d2 == 4'd0)) begin
            es  = '0;
            edp = 1'b0;
        end
`endif
        scan = 1'b1;
        for (int k = 1; k <= int'(N) + 1; k++) push(base + k, 4'b0000, 7'b0, 1'b0);
        if (show) begin
            push(base + int'(N) + 2, p, es, edp);
            push(base + int'(N) + 6, p, es, edp);
        end
        @(negedge clk);
        scan = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push(cyc + 1, 4'b0000, 7'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        push(cyc + 1, 4'b0000, 7'b0, 1'b0);
        @(negedge clk);
    endtask

    // Compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                total++;
                if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== {sbq[i].pos, sbq[i].seg, sbq[i].dp}) begin
                    bad++;
                    $display("FAIL chk%0d cyc=%0d: got pos=%b seg=%b dp=%b, want pos=%b seg=%b dp=%b",
                             sbq[i].tag, cyc, pos, {sa, sb_, sc, sd, se, sf, sg}, dp,
                             sbq[i].pos, sbq[i].seg, sbq[i].dp);
                end
                sbq.delete(i);
            end
        end
    end

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0010, segs("abcdg"),   1'b1};
        vecs[1]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0100, segs("abdeg"),   1'b0};
        vecs[2]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b1000, segs("bc"),      1'b1};
        vecs[3]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0001, segs("bcfg"),    1'b0};
        vecs[4]  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'b0010, segs("adef"),    1'b1};
        vecs[5]  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'b0100, segs("cdefg"),   1'b0};
        vecs[6]  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'b1000, segs("abcefg"),  1'b1};
        vecs[7]  = '{4'hA, 4'hB, 4'hC, 4'hD, 4'b0001, segs("bcdeg"),   1'b0};
        vecs[8]  = '{4'hE, 4'hF, 4'h9, 4'h8, 4'b0010, segs("abcdfg"),  1'b1};
        vecs[9]  = '{4'hE, 4'hF, 4'h9, 4'h8, 4'b0100, segs("aefg"),    1'b0};
        vecs[10] = '{4'hE, 4'hF, 4'h9, 4'h8, 4'b1000, segs("adefg"),   1'b1};
        vecs[11] = '{4'hE, 4'hF, 4'h9, 4'h8, 4'b0001, segs("abcdefg"), 1'b0};
        vecs[12] = '{4'h7, 4'h6, 4'h5, 4'h0, 4'b0010, segs("acdfg"),   1'b1};
        vecs[13] = '{4'h7, 4'h6, 4'h5, 4'h0, 4'b0100, segs("acdefg"),  1'b0};
        vecs[14] = '{4'h7, 4'h6, 4'h5, 4'h0, 4'b1000, segs("abc"),     1'b1};
        vecs[15] = '{4'h7, 4'h6, 4'h5, 4'h0, 4'b0001, segs("abcdef"),  1'b0};

        reset = 1'b1;
        scan  = 1'b0;
        {d3, d2, d1, d0} = '0;
        repeat (3) @(negedge clk);

        // Reset state and parked pointer: dark until the first scan.
        tag = 0;
        do_reset();
        total++;
        if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== 12'b0) begin
            bad++;
            $display("FAIL direct reset check: pos=%b dp=%b", pos, dp);
        end
        for (int k = 1; k <= 3; k++) push(cyc + k, 4'b0000, 7'b0, 1'b0);
        repeat (4) @(negedge clk);

        // One scan per vector, 20 cycles apart; walks digits 1,2,3,0 and all hex codes.
        for (int i = 0; i < 16; i++) begin
            tag = i + 1;
            {d3, d2, d1, d0} = {vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0};
            do_scan(vecs[i].pos, vecs[i].seg, vecs[i].dp, 1'b1);
            repeat (19) @(negedge clk);
        end

        // Live tracking on digit 0: value change shows one clock later.
        tag = 20;
        d0 = 4'h5;
        push(cyc + 1, 4'b0001, segs("acdfg"), 1'b0);
        @(negedge clk);
        d0 = 4'h8;
        push(cyc + 1, 4'b0001, segs("abcdefg"), 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== {4'b0001, segs("abcdefg"), 1'b0}) begin
            bad++;
            $display("FAIL direct live check: pos=%b seg=%b dp=%b", pos, {sa, sb_, sc, sd, se, sf, sg}, dp);
        end

        // Two scans two cycles apart: gap restarts, pointer moves by two.
        tag = 21;
        do_scan(4'b0000, 7'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_scan(4'b0100, segs("acdefg"), 1'b0, 1'b1);
        repeat (19) @(negedge clk);

        // Reset with a coincident scan while lit: reset wins, next scan selects digit 1.
        tag = 22;
        reset = 1'b1;
        scan  = 1'b1;
        push(cyc + 1, 4'b0000, 7'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        scan  = 1'b0;
        push(cyc + 1, 4'b0000, 7'b0, 1'b0);
        @(negedge clk);
        total++;
        if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== 12'b0) begin
            bad++;
            $display("FAIL direct reset+scan check: pos=%b dp=%b", pos, dp);
        end
        tag = 23;
        do_scan(4'b0010, segs("acdfg"), 1'b1, 1'b1);
        repeat (19) @(negedge clk);

        // Reset in the middle of the blank gap.
        tag = 24;
        do_scan(4'b0000, 7'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();
        total++;
        if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== 12'b0) begin
            bad++;
            $display("FAIL direct mid-gap reset check: pos=%b dp=%b", pos, dp);
        end
        tag = 25;
        do_scan(4'b0010, segs("acdfg"), 1'b1, 1'b1);
        repeat (19) @(negedge clk);

        // Leading zeros: displayed by default, blanked when the option is built in.
        tag = 26;
        do_reset();
        total++;
        if ({pos, sa, sb_, sc, sd, se, sf, sg, dp} !== 12'b0) begin
            bad++;
            $display("FAIL direct lzb reset check: pos=%b dp=%b", pos, dp);
        end
        {d3, d2, d1, d0} = {4'h0, 4'h0, 4'h5, 4'h9};
        do_scan(4'b0010, segs("acdfg"),  1'b1, 1'b1); repeat (19) @(negedge clk);
        tag = 27;
        do_scan(4'b0100, segs("abcdef"), 1'b0, 1'b1); repeat (19) @(negedge clk);
        tag = 28;
        do_scan(4'b1000, segs("abcdef"), 1'b1, 1'b1); repeat (19) @(negedge clk);
        tag = 29;
        d3 = 4'h1;
        do_scan(4'b0001, segs("abcdfg"), 1'b0, 1'b1); repeat (19) @(negedge clk);
        tag = 30;
        do_scan(4'b0010, segs("acdfg"),  1'b1, 1'b1); repeat (19) @(negedge clk);
        tag = 31;
        do_scan(4'b0100, segs("abcdef"), 1'b0, 1'b1); repeat (19) @(negedge clk);
        tag = 32;
        do_scan(4'b1000, segs("bc"),     1'b1, 1'b1); repeat (19) @(negedge clk);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 50 && sbq.size() > 0; k++) @(negedge clk);
        while (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL chk%0d due=%0d never compared (cyc=%0d)", sbq[0].tag, sbq[0].due, cyc);
            void'(sbq.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
